// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide-operand adder that streams WIDTH-bit operands
// through a single 4-bit fulladd stage, one nibble per cycle, LSB first.
//
// Optional feature macro: NIBBLE_SERIAL_OVF_EN adds the out_ovf port
// (signed overflow of the completed sum).
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat (IDLE and not in reset)
//   in_a/in_b  WIDTH-bit operands
//   in_cin     carry into slice 0
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_sum    (in_a + in_b + in_cin) mod 2^WIDTH
//   out_cout   carry out of the MSB slice
//   out_ovf    signed overflow (NIBBLE_SERIAL_OVF_EN only)
//   busy       high while an operation is in RUN or DONE

// 4-bit full adder slice.
module fulladd (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  assign {c_out, sum} = 5'(a) + 5'(b) + 5'(c_in);

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef NIBBLE_SERIAL_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [IDX_W+1:0] bit_base;
  logic [3:0]       fa_a;
  logic [3:0]       fa_b;
  logic [3:0]       fa_sum;
  logic             fa_cout;
  logic             accept;

  // Ready is forced low during reset so nothing is accepted on a reset edge.
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Bit offset of the current nibble.
  assign bit_base = {idx, 2'b00};
  assign fa_a     = a_q[bit_base +: 4];
  assign fa_b     = b_q[bit_base +: 4];

  fulladd u_fulladd (
    .a     (fa_a),
    .b     (fa_b),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  // The result registers double as the output registers; they only change
  // in RUN, so they are stable for the whole of DONE.
  assign out_sum  = sum_q;
  assign out_cout = carry_q;

`ifdef NIBBLE_SERIAL_OVF_EN
  logic ovf_q;
  assign out_ovf = ovf_q;
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end

        RUN: begin
          sum_q[bit_base +: 4] <= fa_sum;
          carry_q              <= fa_cout;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef NIBBLE_SERIAL_OVF_EN
            // fa_sum[3] is the sum MSB being written on this same edge.
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fa_sum[3] != a_q[WIDTH-1]);
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic             out_ovf;
`endif

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef NIBBLE_SERIAL_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
    res_t         r;
    logic [WIDTH:0] t;
    int           s;
    t      = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    s      = int'($signed(a)) + int'($signed(b)) + int'(cin);
    r.ovf  = (s > ((1 << (WIDTH-1)) - 1)) || (s < -(1 << (WIDTH-1)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard compare: every cycle a result is presented it must match the
  // oldest outstanding model result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("model_sum", 32'(out_sum), 32'(exp_q[0].sum));
        chk("model_cout", 32'(out_cout), 32'(exp_q[0].cout));
`ifdef NIBBLE_SERIAL_OVF_EN
        chk("model_ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
`endif
      end
      chk("ready_during_valid", 32'(in_ready), 32'd0);
    end
  end

  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand and wait until it is accepted.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("send_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    step();
    acc_cyc = cyc;
    exp_q.push_back(model(a, b, cin));
    // Scramble the inputs: the captured operands must not follow them.
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    in_cin   = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("valid_timeout", 32'(out_valid), 32'd1);
    lat = cyc - acc_cyc;
  endtask

  // Send, wait for the result, check latency and literal sum/cout.
  task automatic op_start(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic cin,
                          input logic [WIDTH-1:0] esum, input logic ecout);
    int lat;
    out_ready = 1'b1;
    send(a, b, cin);
    wait_valid(lat);
    chk({name, "_latency"}, 32'(lat), 32'(NIB));
    chk({name, "_sum"}, 32'(out_sum), 32'(esum));
    chk({name, "_cout"}, 32'(out_cout), 32'(ecout));
  endtask

  // Handshake completes on the next edge; block must be idle afterwards.
  task automatic op_finish(input string name);
    step();
    chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
    chk({name, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
`ifdef NIBBLE_SERIAL_OVF_EN
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: all zeros
    op_start("t1", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
`ifdef NIBBLE_SERIAL_OVF_EN
    chk("t1_ovf", 32'(out_ovf), 32'd0);
`endif
    op_finish("t1");

    // 2: carry ripples through every slice
    op_start("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
`ifdef NIBBLE_SERIAL_OVF_EN
    chk("t2_ovf", 32'(out_ovf), 32'd0);
`endif
    op_finish("t2");

    // 3: positive overflow via carry-in
    op_start("t3", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0);
`ifdef NIBBLE_SERIAL_OVF_EN
    chk("t3_ovf", 32'(out_ovf), 32'd1);
`endif
    op_finish("t3");

    // Extremes: max + max + 1, and most-negative + most-negative
    op_start("tmax", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
`ifdef NIBBLE_SERIAL_OVF_EN
    chk("tmax_ovf", 32'(out_ovf), 32'd0);
`endif
    op_finish("tmax");
    op_start("tneg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
`ifdef NIBBLE_SERIAL_OVF_EN
    chk("tneg_ovf", 32'(out_ovf), 32'd1);
`endif
    op_finish("tneg");

    // 4: backpressure holds the result; new operands are refused
    out_ready = 1'b0;
    send(16'h00FF, 16'h0F01, 1'b1);
    wait_valid(n);
    chk("t4_latency", 32'(n), 32'(NIB));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 16'hAAAA;
      in_b     = 16'h5555;
      in_cin   = 1'b1;
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_sum", 32'(out_sum), 32'h1001);
      chk("t4_hold_cout", 32'(out_cout), 32'd0);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_finish("t4");
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_no_extra_valid", 32'(out_valid), 32'd0);
    end

    // 5: reset during the second RUN cycle discards the operation
    send(16'h1111, 16'h2222, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("t5_ready_in_rst", 32'(in_ready), 32'd0);
    step();
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_sum", 32'(out_sum), 32'd0);
    chk("t5_rst_cout", 32'(out_cout), 32'd0);
    rst = 1'b0;
    #1;
    chk("t5_ready_after_rst", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_no_valid", 32'(out_valid), 32'd0);
    end
    op_start("t5", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    op_finish("t5");

    // 6: random operands back to back, checked by the scoreboard
    $monitor("mon t=%0t out_valid=%b out_sum=%h out_cout=%b", $time, out_valid, out_sum, out_cout);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("t6_drain", 32'(exp_q.size()), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
